// File: rtl/mem_commit_port.sv
// ---------------------------------------------------------------------------
// mem_commit_port
//
// Memory-side responder for the ROB commit interface. Serves committed
// stores (SB/SH/SW) and IO reads (lbu from the IO port). Each request is
// serialised onto the byte-wide RAM/IO bus, one byte per cycle. Completion
// is signalled to the ROB with a one-cycle done pulse plus, for loads, the
// zero-extended byte read back.
//
// The module drives the bus only while a commit is in flight. When idle,
// it drives mem_a=0 and mem_wr=0.
//
// Ports
//   clk                in   1   system clock
//   rst                in   1   asynchronous reset, active-low
//   rdy                in   1   global ready; low freezes all state
//   in_rob_store_flag  in   1   one-cycle store request pulse
//   in_rob_load_flag   in   1   one-cycle IO-read request pulse
//   in_rob_size        in   6   store size in bytes (1/2/4)
//   in_rob_addr        in   32  store address
//   in_rob_data        in   32  store data, little-endian
//   out_rob_done       out  1   one-cycle completion pulse
//   out_rob_data       out  32  IO read byte, zero-extended
//   out_busy           out  1   high whenever a request is in flight
//   mem_din            in   8   RAM/IO read byte (valid 1 cycle after mem_a)
//   mem_dout           out  8   RAM/IO write byte
//   mem_a              out  32  RAM/IO address
//   mem_wr             out  1   1 = write, 0 = read
//   io_buffer_full     in   1   UART tx buffer full
//
// Configuration
//   MEM_COMMIT_IO_STALL_EN
//     When this macro is defined, a store byte aimed at IO space
//     (addr[17:16]==IO_SEL_BITS) is held while io_buffer_full is high.
//     While held, mem_wr is 0, the byte index does not advance, and the
//     done pulse is delayed by the same number of cycles.
//     When the macro is not defined, io_buffer_full is ignored.
// ---------------------------------------------------------------------------
module mem_commit_port #(
  parameter logic [31:0] IO_READ_ADDR = 32'h0003_0000,
  parameter logic [1:0]  IO_SEL_BITS  = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_rob_store_flag,
  input  logic        in_rob_load_flag,
  input  logic [5:0]  in_rob_size,
  input  logic [31:0] in_rob_addr,
  input  logic [31:0] in_rob_data,
  output logic        out_rob_done,
  output logic [31:0] out_rob_data,
  output logic        out_busy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STORE   = 3'd1;
  localparam logic [2:0] S_LD_ADDR = 3'd2;
  localparam logic [2:0] S_LD_WAIT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]  r_state;
  logic [1:0]  r_idx;      // byte currently on the bus
  logic [1:0]  r_last;     // index of the final byte of the store
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_rdata;

  logic        w_size_ok;
  logic [1:0]  w_last_idx;
  logic        w_stall;
  logic        w_last_beat;
  logic [7:0]  w_byte;
  logic [31:0] w_beat_addr;

  // Only 1, 2 and 4 byte stores go on the bus. Any other size completes
  // at once without writing anything.
  always_comb begin
    w_size_ok  = 1'b0;
    w_last_idx = 2'd0;
    case (in_rob_size)
      6'd1: begin w_size_ok = 1'b1; w_last_idx = 2'd0; end
      6'd2: begin w_size_ok = 1'b1; w_last_idx = 2'd1; end
      6'd4: begin w_size_ok = 1'b1; w_last_idx = 2'd3; end
      default: begin w_size_ok = 1'b0; w_last_idx = 2'd0; end
    endcase
  end

`ifdef MEM_COMMIT_IO_STALL_EN
  // A store to IO space waits for room in the UART tx buffer.
  assign w_stall = (r_addr[17:16] == IO_SEL_BITS) && io_buffer_full;
`else
  // Stall disabled: io_buffer_full is read but masked off, so the port
  // stays connected without affecting behaviour.
  assign w_stall = io_buffer_full & 1'b0;
`endif

  assign w_last_beat = (r_idx == r_last);

  // The address adds the byte index to the base and wraps at 32 bits.
  // A store is never split into separate requests.
  assign w_beat_addr = r_addr + {30'd0, r_idx};

  always_comb begin
    w_byte = 8'd0;
    case (r_idx)
      2'd0: w_byte = r_data[7:0];
      2'd1: w_byte = r_data[15:8];
      2'd2: w_byte = r_data[23:16];
      2'd3: w_byte = r_data[31:24];
      default: w_byte = 8'd0;
    endcase
  end

  // State register and request capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_last  <= 2'd0;
      r_addr  <= 32'd0;
      r_data  <= 32'd0;
      r_rdata <= 32'd0;
    end else if (rdy) begin
      case (r_state)
        S_IDLE: begin
          // When both flags are high, the store wins and the load flag
          // is dropped.
          if (in_rob_store_flag) begin
            r_addr <= in_rob_addr;
            r_data <= in_rob_data;
            r_idx  <= 2'd0;
            r_last <= w_last_idx;
            r_state <= w_size_ok ? S_STORE : S_DONE;
          end else if (in_rob_load_flag) begin
            r_state <= S_LD_ADDR;
          end
        end
        S_STORE: begin
          if (!w_stall) begin
            if (w_last_beat) begin
              r_state <= S_IDLE;
              r_idx   <= 2'd0;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        S_LD_ADDR: r_state <= S_LD_WAIT;
        S_LD_WAIT: begin
          // mem_din answers the address driven in the previous cycle.
          r_rdata <= {24'd0, mem_din};
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus and ROB outputs
  // While rdy is low, the write strobe and the done pulse are masked.
  // The state itself holds, so a pending done pulse is delayed rather
  // than lost.
  always_comb begin
    mem_a        = 32'd0;
    mem_dout     = 8'd0;
    mem_wr       = 1'b0;
    out_rob_done = 1'b0;
    case (r_state)
      S_STORE: begin
        mem_a        = w_beat_addr;
        mem_dout     = w_byte;
        mem_wr       = rdy && !w_stall;
        out_rob_done = rdy && !w_stall && w_last_beat;
      end
      S_LD_ADDR: begin
        mem_a = IO_READ_ADDR;
      end
      S_DONE: begin
        out_rob_done = rdy;
      end
      default: begin
        mem_a = 32'd0;
      end
    endcase
  end

  assign out_rob_data = r_rdata;
  assign out_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_commit_port.sv
module tb_mem_commit_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_rob_store_flag;
  logic        in_rob_load_flag;
  logic [5:0]  in_rob_size;
  logic [31:0] in_rob_addr;
  logic [31:0] in_rob_data;
  logic        out_rob_done;
  logic [31:0] out_rob_data;
  logic        out_busy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int errors = 0;
  int checks = 0;

  mem_commit_port dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .in_rob_store_flag (in_rob_store_flag),
    .in_rob_load_flag  (in_rob_load_flag),
    .in_rob_size       (in_rob_size),
    .in_rob_addr       (in_rob_addr),
    .in_rob_data       (in_rob_data),
    .out_rob_done      (out_rob_done),
    .out_rob_data      (out_rob_data),
    .out_busy          (out_busy),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr),
    .io_buffer_full    (io_buffer_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_store(input logic [5:0] sz, input logic [31:0] a, input logic [31:0] d);
    in_rob_store_flag = 1'b1;
    in_rob_size = sz;
    in_rob_addr = a;
    in_rob_data = d;
    tick();
    in_rob_store_flag = 1'b0;
    in_rob_load_flag  = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [7:0] d,
                          input logic done);
    chk({tag, ".a"},    mem_a, a);
    chk({tag, ".dout"}, {24'd0, mem_dout}, {24'd0, d});
    chk({tag, ".wr"},   {31'd0, mem_wr}, 32'd1);
    chk({tag, ".done"}, {31'd0, out_rob_done}, {31'd0, done});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, {31'd0, out_busy}, 32'd0);
    chk({tag, ".done"}, {31'd0, out_rob_done}, 32'd0);
    chk({tag, ".wr"},   {31'd0, mem_wr}, 32'd0);
    chk({tag, ".a"},    mem_a, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    in_rob_store_flag = 1'b0;
    in_rob_load_flag  = 1'b0;
    in_rob_size = 6'd0;
    in_rob_addr = 32'd0;
    in_rob_data = 32'd0;
    mem_din = 8'd0;
    io_buffer_full = 1'b0;

    // Reset state
    tick();
    tick();
    chk_idle("rst");
    chk("rst.data", out_rob_data, 32'd0);
    rst = 1'b1;
    tick();

    // SW 0xDDCCBBAA @ 0x100
    req_store(6'd4, 32'h100, 32'hDDCCBBAA);
    chk_beat("sw.b0", 32'h100, 8'hAA, 1'b0);
    tick();
    chk_beat("sw.b1", 32'h101, 8'hBB, 1'b0);
    tick();
    chk_beat("sw.b2", 32'h102, 8'hCC, 1'b0);
    tick();
    chk_beat("sw.b3", 32'h103, 8'hDD, 1'b1);
    tick();
    chk_idle("sw.end");

    // SB to IO space with the tx buffer full for two cycles
    io_buffer_full = 1'b1;
    req_store(6'd1, 32'h30000, 32'h41);
`ifdef MEM_COMMIT_IO_STALL_EN
    chk("sb.t1.wr",   {31'd0, mem_wr}, 32'd0);
    chk("sb.t1.done", {31'd0, out_rob_done}, 32'd0);
    tick();
    chk("sb.t2.wr",   {31'd0, mem_wr}, 32'd0);
    chk("sb.t2.done", {31'd0, out_rob_done}, 32'd0);
    io_buffer_full = 1'b0;
    tick();
    chk_beat("sb.t3", 32'h30000, 8'h41, 1'b1);
`else
    chk_beat("sb.t1", 32'h30000, 8'h41, 1'b1);
    tick();
    chk_idle("sb.t2");
    io_buffer_full = 1'b0;
    tick();
`endif
    tick();
    chk_idle("sb.end");

    // IO load: read 0x7A
    in_rob_load_flag = 1'b1;
    tick();
    in_rob_load_flag = 1'b0;
    chk("ld.t1.a",    mem_a, 32'h30000);
    chk("ld.t1.wr",   {31'd0, mem_wr}, 32'd0);
    chk("ld.t1.done", {31'd0, out_rob_done}, 32'd0);
    tick();
    mem_din = 8'h7A;
    chk("ld.t2.done", {31'd0, out_rob_done}, 32'd0);
    tick();
    mem_din = 8'h00;
    chk("ld.t3.done", {31'd0, out_rob_done}, 32'd1);
    chk("ld.t3.data", out_rob_data, 32'h0000007A);
    tick();
    chk_idle("ld.end");
    chk("ld.hold", out_rob_data, 32'h0000007A);

    // Store and load requested in the same cycle: only the store is served
    in_rob_load_flag = 1'b1;
    req_store(6'd1, 32'h200, 32'h55);
    chk_beat("both.t1", 32'h200, 8'h55, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_idle("both.after");
    end
    chk("both.data", out_rob_data, 32'h0000007A);

    // SH with the address wrapping past 0xFFFFFFFF
    req_store(6'd2, 32'hFFFFFFFF, 32'h1234);
    chk_beat("sh.b0", 32'hFFFFFFFF, 8'h34, 1'b0);
    tick();
    chk_beat("sh.b1", 32'h00000000, 8'h12, 1'b1);
    tick();
    chk_idle("sh.end");

    // Unsupported size: no bus write, done at T+1
    req_store(6'd3, 32'h300, 32'hFFFFFFFF);
    chk("bad.wr",   {31'd0, mem_wr}, 32'd0);
    chk("bad.done", {31'd0, out_rob_done}, 32'd1);
    tick();
    chk_idle("bad.end");

    // SW with rdy low for three cycles from T+2, then reset at T+6
    req_store(6'd4, 32'h100, 32'hDDCCBBAA);
    chk_beat("rdy.b0", 32'h100, 8'hAA, 1'b0);
    tick();
    rdy = 1'b0;
    #1;
    chk("rdy.t2.wr",   {31'd0, mem_wr}, 32'd0);
    chk("rdy.t2.a",    mem_a, 32'h101);
    chk("rdy.t2.done", {31'd0, out_rob_done}, 32'd0);
    tick();
    chk("rdy.t3.wr",   {31'd0, mem_wr}, 32'd0);
    tick();
    chk("rdy.t4.wr",   {31'd0, mem_wr}, 32'd0);
    chk("rdy.t4.busy", {31'd0, out_busy}, 32'd1);
    tick();
    rdy = 1'b1;
    #1;
    chk_beat("rdy.t5", 32'h101, 8'hBB, 1'b0);
    tick();
    chk_beat("rdy.t6", 32'h102, 8'hCC, 1'b0);
    rst = 1'b0;
    #1;
    chk_idle("rdy.rst");
    chk("rdy.rst.data", out_rob_data, 32'd0);
    chk("rdy.rst.dout", {24'd0, mem_dout}, 32'd0);
    tick();
    chk_idle("rdy.rst2");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("rdy.post");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
